// File: rtl/pack_s3_seq.sv
// S3 packing sequencer: collects five trits per group, drives the trit5_to_bit8
// converter through load/accumulate phases and emits one packed byte per group.
module pack_s3_seq #(
    parameter int unsigned N_COEF = 700,
    parameter int unsigned N_BYTE = N_COEF / 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [1:0] s_trit,
    input  logic       s_last,
    output logic       s_ready,
    output logic [9:0] conv_a,
    output logic       conv_rst,
    output logic [1:0] conv_count,
    input  logic [7:0] conv_out,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_byte,
    output logic       m_last,
    output logic       err
);

    localparam int unsigned BW = (N_BYTE > 1) ? $clog2(N_BYTE) : 1;
    localparam logic [BW-1:0] LAST_B = BW'(N_BYTE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, HOLD} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [2:0]    tcnt_q, tcnt_d;
    logic [9:0]    grp_q, grp_d;
    logic          full_q, full_d;
    logic          glast_q, glast_d;
    logic [9:0]    conv_a_q, conv_a_d;
    logic          elast_q, elast_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_byte_q, m_byte_d;
    logic          m_last_q, m_last_d;
    logic          err_q, err_d;

    logic       take;
    logic       ready_c;
    logic       accept;
    logic [1:0] trit_w;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        tcnt_d    = tcnt_q;
        grp_d     = grp_q;
        full_d    = full_q;
        glast_d   = glast_q;
        conv_a_d  = conv_a_q;
        elast_d   = elast_q;
        bcnt_d    = bcnt_q;
        m_valid_d = m_valid_q;
        m_byte_d  = m_byte_q;
        m_last_d  = m_last_q;
        err_d     = err_q;
        trit_w    = '0;

        // The engine takes a waiting group from IDLE, or straight from HOLD on the
        // output handshake; the buffer is freed in that same cycle.
        take    = full_q && ((state_q == IDLE) || ((state_q == HOLD) && m_ready));
        ready_c = !rst && (!full_q || take);
        accept  = s_valid && ready_c;

        if (take) begin
            conv_a_d = grp_q;
            elast_d  = glast_q;
            grp_d    = '0;
            full_d   = 1'b0;
            glast_d  = 1'b0;
        end

        if (accept) begin
            trit_w = (s_trit == 2'b10) ? 2'b00 : s_trit;
            if (s_trit == 2'b10) begin
                err_d = 1'b1;
            end
            for (int unsigned k = 0; k < 5; k++) begin
                if (tcnt_q == 3'(k)) begin
                    grp_d[2*k +: 2] = trit_w;
                end
            end
            if ((tcnt_q == 3'd4) || s_last) begin
                full_d  = 1'b1;
                glast_d = s_last;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 3'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = LOAD;
                    ph_d    = '0;
                end
            end
            LOAD: begin
                if (ph_q == 2'd1) begin
                    state_d = ACC;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            ACC: begin
                if (ph_q == 2'd3) begin
                    state_d   = HOLD;
                    ph_d      = '0;
                    m_valid_d = 1'b1;
                    m_byte_d  = conv_out;
                    m_last_d  = elast_q || (bcnt_q == LAST_B);
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    bcnt_d    = m_last_q ? '0 : bcnt_q + BW'(1);
                    state_d   = take ? LOAD : IDLE;
                    ph_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            tcnt_q    <= '0;
            grp_q     <= '0;
            full_q    <= 1'b0;
            glast_q   <= 1'b0;
            conv_a_q  <= '0;
            elast_q   <= 1'b0;
            bcnt_q    <= '0;
            m_valid_q <= 1'b0;
            m_byte_q  <= '0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            tcnt_q    <= tcnt_d;
            grp_q     <= grp_d;
            full_q    <= full_d;
            glast_q   <= glast_d;
            conv_a_q  <= conv_a_d;
            elast_q   <= elast_d;
            bcnt_q    <= bcnt_d;
            m_valid_q <= m_valid_d;
            m_byte_q  <= m_byte_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
        end
    end

    assign s_ready    = ready_c;
    assign conv_a     = conv_a_q;
    assign conv_rst   = (state_q == LOAD);
    assign conv_count = (state_q == ACC) ? ph_q : 2'b00;
    assign m_valid    = m_valid_q;
    assign m_byte     = m_byte_q;
    assign m_last     = m_last_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pack_s3_seq.sv
// Bench for pack_s3_seq: behavioural trit5_to_bit8 stand-in, directed and random
// groups checked against an arithmetic reference of sum(t_k * 3^k) per group.
module tb_pack_s3_seq;

    localparam int unsigned N_BYTE = 140;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [1:0] s_trit = '0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [9:0] conv_a;
    logic       conv_rst;
    logic [1:0] conv_count;
    logic [7:0] conv_out;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_byte;
    logic       m_last;
    logic       err;

    pack_s3_seq #(.N_COEF(700), .N_BYTE(140)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_trit(s_trit), .s_last(s_last),
        .s_ready(s_ready), .conv_a(conv_a), .conv_rst(conv_rst), .conv_count(conv_count),
        .conv_out(conv_out), .m_valid(m_valid), .m_ready(m_ready), .m_byte(m_byte),
        .m_last(m_last), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned tv(input logic [1:0] t);
        case (t)
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned pw3(input int unsigned k);
        int unsigned r = 1;
        for (int unsigned i = 0; i < k; i++) r = r * 3;
        return r;
    endfunction

    function automatic logic [1:0] enc(input int unsigned v);
        return (v == 1) ? 2'b01 : (v == 2) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [9:0] g5(input int unsigned a, b, c, d, e);
        return {enc(e), enc(d), enc(c), enc(b), enc(a)};
    endfunction

    // Converter stand-in: latch on the load posedge, preload x4 term, add one term per count.
    logic [9:0] a_lat = '0;
    logic [7:0] acc = '0;
    always @(posedge clk) if (conv_rst) a_lat <= conv_a;
    always @(negedge clk) begin
        if (conv_rst) acc <= 8'(tv(a_lat[9:8]) * 81);
        else          acc <= acc + 8'(tv(a_lat[{conv_count, 1'b0} +: 2]) * pw3(32'(conv_count)));
    end
    assign conv_out = acc;

    logic [7:0] got_b[$];
    logic       got_l[$];
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            got_b.push_back(m_byte);
            got_l.push_back(m_last);
        end
    end

    logic rnd_rdy = 1'b0;
    always @(posedge clk) begin
        #2;
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    logic [7:0]  exp_b[$];
    logic        exp_l[$];
    int unsigned mdl_bcnt = 0;
    logic        exp_err = 1'b0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned max_wait = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_trit(input logic [1:0] t, input logic l);
        int unsigned w = 0;
        s_valid = 1'b1;
        s_trit  = t;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && w < 60) begin
            step();
            @(negedge clk);
            w++;
        end
        if (w >= 60) check("s_ready_timeout", w, 0);
        if (w > max_wait) max_wait = w;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_group(input logic [9:0] g, input int unsigned n, input logic l);
        int unsigned v = 0;
        logic [1:0]  t;
        logic        el;
        for (int unsigned k = 0; k < n; k++) begin
            t = g[2*k +: 2];
            if (t == 2'b10) exp_err = 1'b1;
            v += tv(t) * pw3(k);
            send_trit(t, l && (k == n - 1));
        end
        el = l || (mdl_bcnt == N_BYTE - 1);
        exp_b.push_back(8'(v));
        exp_l.push_back(el);
        mdl_bcnt = el ? 0 : mdl_bcnt + 1;
    endtask

    task automatic drain(input string tag);
        int unsigned w = 0;
        logic [7:0]  eb, gb;
        logic        el, gl;
        while (got_b.size() < exp_b.size() && w < 400) begin
            step();
            w++;
        end
        check({tag, "_count"}, got_b.size(), exp_b.size());
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            eb = exp_b.pop_front(); el = exp_l.pop_front();
            gb = got_b.pop_front(); gl = got_l.pop_front();
            check({tag, "_byte"}, gb, eb);
            check({tag, "_last"}, gl, el);
        end
        exp_b.delete(); exp_l.delete();
        got_b.delete(); got_l.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("s_ready_in_rst", s_ready, 0);
        step();
        rst = 1'b0;
        exp_b.delete(); exp_l.delete();
        got_b.delete(); got_l.delete();
        mdl_bcnt = 0;
        exp_err  = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", s_ready, 1);
        check("err_after_rst", err, 0);
        check("m_valid_after_rst", m_valid, 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic seen;
        int unsigned n;
        logic l;

        repeat (3) step();
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_conv_a", conv_a, 0);
        check("rst_conv_rst", conv_rst, 0);
        check("rst_conv_count", conv_count, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_byte", m_byte, 0);
        check("rst_m_last", m_last, 0);
        check("rst_err", err, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_first_cycle", s_ready, 1);
        step();

        // Phase timing after the 5th trit: IDLE, LOAD x2, ACC count 0..3, then valid.
        send_group(g5(1, 0, 0, 0, 0), 5, 1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            check("lat_conv_rst", conv_rst, (i == 1 || i == 2) ? 1 : 0);
            check("lat_conv_count", conv_count, (i >= 3 && i <= 6) ? i - 3 : 0);
            check("lat_m_valid", m_valid, (i == 7) ? 1 : 0);
            if (i == 1) check("lat_conv_a", conv_a, 10'h001);
            step();
        end
        drain("t1");

        send_group(g5(2, 1, 0, 1, 2), 5, 1'b0);
        send_group(g5(2, 2, 2, 2, 2), 5, 1'b0);
        send_group(g5(0, 0, 0, 0, 0), 5, 1'b0);
        drain("vals");

        do_reset();
        max_wait = 0;
        for (int unsigned f = 0; f < N_BYTE; f++) begin
            if (f % 2 == 0) send_group(g5(1, 2, 1, 2, 1), 5, 1'b0);
            else            send_group(g5(2, 1, 2, 1, 2), 5, 1'b0);
        end
        drain("frame");
        check("frame_block_le7", (max_wait <= 7) ? 1 : 0, 1);

        send_group(g5(1, 1, 0, 0, 0), 2, 1'b1);
        drain("short");
        check("short_tcnt", dut.tcnt_q, 0);
        check("short_bcnt", dut.bcnt_q, 0);

        m_ready = 1'b0;
        send_group(g5(2, 0, 1, 0, 0), 5, 1'b0);
        send_group(g5(0, 2, 0, 0, 1), 5, 1'b0);
        repeat (3) step();
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", m_valid, 1);
            check("stall_byte", m_byte, exp_b[0]);
            check("stall_last", m_last, exp_l[0]);
            check("stall_s_ready", s_ready, 0);
            step();
        end
        m_ready = 1'b1;
        drain("stall");

        send_group(10'b00_00_00_01_10, 5, 1'b0);
        drain("illegal");
        @(negedge clk);
        check("illegal_err", err, 1);
        step();

        send_group(g5(2, 2, 0, 0, 0), 5, 1'b0);
        repeat (4) step();
        do_reset();
        seen = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
            step();
        end
        check("abort_no_valid", seen, 0);
        check("abort_err", err, 0);
        send_group(g5(1, 2, 1, 0, 0), 5, 1'b0);
        drain("post_abort");

        rnd_rdy = 1'b1;
        for (int unsigned i = 0; i < 30; i++) begin
            n = $urandom_range(1, 5);
            l = (n < 5) ? 1'b1 : ($urandom_range(0, 3) == 0);
            send_group(10'($urandom()), n, l);
        end
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        drain("rand");
        @(negedge clk);
        check("rand_err", err, exp_err);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pack_s3_seq.md
Name: pack_s3_seq

Overview:
- Upstream sequencer for the S3 packing path of NTRU-HRSS.
- Accepts a serial stream of mod-3 coefficients (trits) over a valid/ready handshake and groups them five at a time into a 10-bit word.
- Drives the trit5_to_bit8 converter's load/count interface and returns each packed byte on a valid/ready output stream with frame-end marking.
- Sits between the polynomial coefficient source and the packed-byte sink.

Parameters:
- N_COEF, 700: coefficients per frame; a multiple of 5.
- N_BYTE, 140: bytes per frame, N_COEF/5.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  trit valid
- s_trit  in  2  trit: 00=0, 01=1, 11=2; 10 illegal
- s_last  in  1  final trit of frame
- s_ready  out  1  sequencer can accept a trit
- conv_a  out  10  5-trit word to converter; trit k on bits [2k+1:2k], weight 3^k
- conv_rst  out  1  converter load strobe
- conv_count  out  2  converter partial-term select
- conv_out  in  8  converter accumulated byte
- m_valid  out  1  packed byte valid
- m_byte  out  8  packed byte
- m_last  out  1  last byte of frame
- err  out  1  sticky illegal-trit flag

Behaviour:
- Reset values: s_ready=0 during rst, 1 on the first cycle after. conv_a=0, conv_rst=0, conv_count=0, m_valid=0, m_byte=0, m_last=0, err=0. tcnt=0, bcnt=0. Collect buffer empty. FSM in IDLE.
- Reset mid-operation aborts everything: partial group, in-flight conversion and pending byte are all discarded.
- Collect side:
  - A trit is accepted on s_valid&s_ready and written to slot tcnt of the collect buffer; tcnt increments.
  - s_ready=0 while the buffer holds a complete group not yet handed to the engine.
  - Illegal 10 is stored as 00 and sets err (cleared only by rst).
  - Group completes when tcnt reaches 4 with a trit accepted, or when s_last is accepted. On s_last, remaining slots are zero-padded and the frame-end flag is captured with the group.
- Engine FSM (IDLE, LOAD, ACC, HOLD):
  - IDLE: when a complete group exists, copy it to conv_a, free the buffer (s_ready may be 1 the same cycle), go to LOAD.
  - LOAD: exactly 2 cycles with conv_rst=1. The first posedge lets the converter latch conv_a; the second negedge preloads the x4 term. Then go to ACC.
  - ACC: exactly 4 cycles, conv_rst=0, conv_count=0,1,2,3 in order. At the posedge ending the 4th cycle, capture conv_out into m_byte, set m_valid=1, set m_last=frame-end flag, go to HOLD.
  - HOLD: keep m_byte and m_last stable while m_valid & !m_ready. On handshake, drop m_valid and go to IDLE; if a group is already waiting, IDLE is skipped and LOAD starts the next cycle.
- Timing:
  - conv_a is stable from LOAD entry until HOLD exit.
  - Latency from group-complete to m_valid is 7 cycles with the engine idle (1 IDLE + 2 LOAD + 4 ACC).
  - Collection of the next group overlaps the engine, so throughput is 1 byte per 7 cycles at most.
- Frame counting:
  - bcnt counts emitted bytes. m_last=1 on the byte carrying the s_last flag, or when bcnt=N_BYTE-1, whichever comes first.
  - bcnt and tcnt clear after the m_last handshake.
  - s_last asserted exactly on trit 5 of a group produces no padding.
- Simultaneous events:
  - Accepting the 5th trit while the engine is in HOLD: the group waits in the buffer and s_ready=0 until the engine takes it.
  - s_last with tcnt=0 (empty group) never occurs by protocol. If it does, an all-zero byte with m_last=1 is emitted.
- Byte value equals the sum over k of t_k*3^k, range 0..242. No overflow is possible in 8 bits.

Test Plan:
- Trits 1,0,0,0,0, m_ready=1 -> conv_rst high 2 cycles, conv_count 0..3, then m_byte=0x01 exactly 7 cycles after the 5th trit is accepted.
- Trits 2,1,0,1,2 -> m_byte=194. Trits 2,2,2,2,2 -> m_byte=242. Trits 0,0,0,0,0 -> m_byte=0.
- Full frame of 700 trits alternating 1,2 with m_ready=1 -> 140 bytes. m_last=1 only on byte 140. s_ready never blocks more than 7 cycles.
- s_last on the 2nd trit of a group (1,1) -> m_byte=4, m_last=1, bcnt and tcnt return to 0.
- m_ready=0 for 10 cycles with 5 more trits offered -> m_byte/m_last stable, s_ready drops after the 5th trit, both bytes delivered in order after release.
- Illegal 10 as trit 0 followed by 1,0,0,0 -> err=1, m_byte=3. Pulse rst during ACC -> m_valid stays 0, err=0, next group converts correctly.
